// File: rtl/ntsc_timing_pkg.sv
// NTSC line/frame timing constants, line-state and video_sel encodings.
// Shared by the counter, the sequencer top and the fetch interface users.
package ntsc_timing_pkg;

  localparam int unsigned LineClks   = 3175;
  localparam int unsigned HsyncClks  = 235;
  localparam int unsigned BreezeClks = 30;
  localparam int unsigned BurstClks  = 125;
  localparam int unsigned BporchClks = 80;
  localparam int unsigned FporchClks = 75;
  localparam int unsigned PixClks    = 10;
  localparam int unsigned HPixels    = 256;
  localparam int unsigned VLines     = 262;
  localparam int unsigned VFirst     = 22;
  localparam int unsigned VPixels    = 240;
  localparam int unsigned PixOffset  = 35;   // active start to first pixel

  localparam logic [5:0] BurstColour  = 6'h08;
  localparam logic [5:0] BorderColour = 6'h0F;

  localparam int unsigned HCntW = 12;
  localparam int unsigned VCntW = 9;
  localparam int unsigned PhW   = 4;

  // Horizontal boundaries (state starts) and derived pixel-fetch points.
  localparam logic [HCntW-1:0] HLast       = HCntW'(LineClks - 1);
  localparam logic [HCntW-1:0] HBreeze     = HCntW'(HsyncClks);
  localparam logic [HCntW-1:0] HBurst      = HCntW'(HsyncClks + BreezeClks);
  localparam logic [HCntW-1:0] HBporch     = HCntW'(HsyncClks + BreezeClks + BurstClks);
  localparam logic [HCntW-1:0] HActive     = HCntW'(HsyncClks + BreezeClks + BurstClks +
                                                    BporchClks);
  localparam logic [HCntW-1:0] HFporch     = HCntW'(LineClks - FporchClks);
  localparam logic [HCntW-1:0] HPixStart   = HCntW'(HsyncClks + BreezeClks + BurstClks +
                                                    BporchClks + PixOffset);
  localparam logic [HCntW-1:0] HPixEnd     = HCntW'(HsyncClks + BreezeClks + BurstClks +
                                                    BporchClks + PixOffset + HPixels * PixClks);
  localparam logic [HCntW-1:0] HReqStart   = HPixStart - HCntW'(PixClks);
  localparam logic [HCntW-1:0] HReqLast    = HPixEnd - HCntW'(2 * PixClks);
  localparam logic [HCntW-1:0] HReqPrep    = HReqStart - HCntW'(1);
  localparam logic [HCntW-1:0] HVsyncBlank = HCntW'(LineClks - HsyncClks);

  localparam logic [PhW-1:0] PhLast = PhW'(PixClks - 1);

  // Vertical boundaries.
  localparam logic [VCntW-1:0] VLast       = VCntW'(VLines - 1);
  localparam logic [VCntW-1:0] VFirstLine  = VCntW'(VFirst);
  localparam logic [VCntW-1:0] VEndLine    = VCntW'(VFirst + VPixels);
  localparam logic [VCntW-1:0] VNoBurstEnd = VCntW'(9);
  localparam logic [VCntW-1:0] VVsyncFirst = VCntW'(3);
  localparam logic [VCntW-1:0] VVsyncLast  = VCntW'(5);

  typedef enum logic [2:0] {
    StSync, StBreeze, StBurst, StBporch, StActive, StFporch
  } line_state_e;

  typedef enum logic [1:0] {
    SelSync   = 2'd0,
    SelBlank  = 2'd1,
    SelBurst  = 2'd2,
    SelActive = 2'd3
  } video_sel_e;

  function automatic line_state_e decode_state(input logic [HCntW-1:0] h);
    line_state_e st;
    if (h < HBreeze)      st = StSync;
    else if (h < HBurst)  st = StBreeze;
    else if (h < HBporch) st = StBurst;
    else if (h < HActive) st = StBporch;
    else if (h < HFporch) st = StActive;
    else                  st = StFporch;
    return st;
  endfunction

endpackage

// File: rtl/ntsc_line_sequencer_if.sv
// Frame-buffer pixel fetch handshake: request with column/row, valid with colour.
interface ntsc_line_sequencer_if;
  logic       pix_req;
  logic [7:0] pix_x;
  logic [7:0] pix_y;
  logic       pix_valid;
  logic [5:0] pix_colour;

  modport master (output pix_req, pix_x, pix_y, input pix_valid, pix_colour);
  modport slave  (input pix_req, pix_x, pix_y, output pix_valid, pix_colour);
endinterface

// File: rtl/ntsc_hv_counter.sv
// Horizontal/vertical position counters with registered line/frame start pulses.
module ntsc_hv_counter
  import ntsc_timing_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [HCntW-1:0] h_cnt_o,
  output logic [VCntW-1:0] v_cnt_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  logic [HCntW-1:0] h_q, h_d;
  logic [VCntW-1:0] v_q, v_d;
  logic             line_start_q, frame_start_q;

  // Next position: h wraps at line end, v steps on that wrap.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end
  end

  // Counters and pulses; pulses share the one-cycle output latency of the video path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      line_start_q  <= (h_q == '0);
      frame_start_q <= (h_q == '0) && (v_q == '0);
    end
  end

  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/ntsc_line_sequencer.sv
// NTSC line sequencer: decodes line state from h/v position, drives the colour
// code and DAC level-select (registered), and fetches pixels one pixel ahead.
// Build option: VSYNC_SERRATION_EN selects equalizing/serrated vertical sync;
// without it lines 3..5 carry a plain broad sync pulse.
module ntsc_line_sequencer
  import ntsc_timing_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  ntsc_line_sequencer_if.master        fetch_if,
  output logic [5:0]                   colour_num_o,
  output logic [1:0]                   video_sel_o,
  output logic                         line_start_o,
  output logic                         frame_start_o,
  output logic                         underrun_o
);

`ifdef VSYNC_SERRATION_EN
  localparam logic [HCntW-1:0] HEqEnd     = HCntW'(115);
  localparam logic [HCntW-1:0] HHalf      = HCntW'(1587);
  localparam logic [HCntW-1:0] HHalfEqEnd = HCntW'(1587 + 115);
  localparam logic [HCntW-1:0] HSerrGap   = HCntW'(1587 - 235);
  logic eq_line;
`endif

  logic [HCntW-1:0] h_cnt;
  logic [VCntW-1:0] v_cnt;
  line_state_e      state;
  logic             vis_line, no_burst_line, vsync_line, in_window;
  logic             boundary, take, deadline, issue;
  logic [5:0]       shown;

  video_sel_e       sel_q, sel_d;
  logic [5:0]       colour_q, colour_d;
  logic             req_q, req_d, pend_q, pend_d, got_q, got_d, under_q, under_d;
  logic [7:0]       x_q, x_d, y_q, y_d, n_q, n_d;
  logic [5:0]       buf_q, buf_d, cur_q, cur_d;
  logic [PhW-1:0]   ph_q, ph_d;

  ntsc_hv_counter u_hv (
    .clk          (clk),
    .reset        (reset),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .line_start_o (line_start_o),
    .frame_start_o(frame_start_o)
  );

  assign state         = decode_state(h_cnt);
  assign vis_line      = (v_cnt >= VFirstLine) && (v_cnt < VEndLine);
  assign no_burst_line = (v_cnt < VNoBurstEnd);
  assign vsync_line    = (v_cnt >= VVsyncFirst) && (v_cnt <= VVsyncLast);
  assign in_window     = vis_line && (h_cnt >= HPixStart) && (h_cnt < HPixEnd);
  // ph_q is zero on every pixel boundary from HReqStart onward.
  assign boundary      = (ph_q == '0);
  assign deadline      = in_window && boundary;
  assign issue         = vis_line && boundary && (h_cnt >= HReqStart) && (h_cnt <= HReqLast);
  assign take          = pend_q && fetch_if.pix_valid;
`ifdef VSYNC_SERRATION_EN
  assign eq_line       = no_burst_line && !vsync_line;
`endif

  // Fetch pipeline: request pixel n one pixel early, resolve it at its boundary.
  always_comb begin
    ph_d    = (h_cnt == HReqPrep || ph_q == PhLast) ? '0 : ph_q + 1'b1;
    n_d     = (h_cnt == HReqPrep) ? '0 : n_q;
    req_d   = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    pend_d  = pend_q;
    got_d   = got_q;
    buf_d   = buf_q;
    cur_d   = cur_q;
    under_d = under_q;
    shown   = cur_q;
    if (take) begin
      buf_d = fetch_if.pix_colour;
      got_d = 1'b1;
    end
    if (deadline) begin
      if (take)       shown = fetch_if.pix_colour;
      else if (got_q) shown = buf_q;
      else begin
        shown   = BorderColour;
        under_d = 1'b1;
      end
      cur_d  = shown;
      pend_d = 1'b0;
      got_d  = 1'b0;
    end
    // The next request shares the cycle with the previous pixel's deadline.
    if (issue) begin
      req_d  = 1'b1;
      x_d    = n_q;
      y_d    = 8'(v_cnt - VFirstLine);
      n_d    = n_q + 1'b1;
      pend_d = 1'b1;
      got_d  = 1'b0;
    end
  end

  // Video level-select and colour code for the current position.
  always_comb begin
    sel_d    = SelBlank;
    colour_d = BorderColour;
    unique case (state)
      StSync:   sel_d = SelSync;
      StBurst: begin
        if (!no_burst_line) begin
          sel_d    = SelBurst;
          colour_d = BurstColour;
        end
      end
      StActive: begin
        sel_d = SelActive;
        if (in_window) colour_d = shown;
      end
      default:  sel_d = SelBlank;
    endcase
`ifdef VSYNC_SERRATION_EN
    if (eq_line) begin
      sel_d    = (h_cnt < HEqEnd || (h_cnt >= HHalf && h_cnt < HHalfEqEnd)) ? SelSync : SelBlank;
      colour_d = BorderColour;
    end
    if (vsync_line) begin
      sel_d    = ((h_cnt >= HSerrGap && h_cnt < HHalf) || h_cnt >= HVsyncBlank) ?
                 SelBlank : SelSync;
      colour_d = BorderColour;
    end
`else
    if (vsync_line) sel_d = (h_cnt < HVsyncBlank) ? SelSync : SelBlank;
`endif
  end

  // Output and fetch state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= SelSync;
      colour_q <= BorderColour;
      req_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      n_q      <= '0;
      pend_q   <= 1'b0;
      got_q    <= 1'b0;
      buf_q    <= BorderColour;
      cur_q    <= BorderColour;
      under_q  <= 1'b0;
      ph_q     <= '0;
    end else begin
      sel_q    <= sel_d;
      colour_q <= colour_d;
      req_q    <= req_d;
      x_q      <= x_d;
      y_q      <= y_d;
      n_q      <= n_d;
      pend_q   <= pend_d;
      got_q    <= got_d;
      buf_q    <= buf_d;
      cur_q    <= cur_d;
      under_q  <= under_d;
      ph_q     <= ph_d;
    end
  end

  assign colour_num_o     = colour_q;
  assign video_sel_o      = sel_q;
  assign underrun_o       = under_q;
  assign fetch_if.pix_req = req_q;
  assign fetch_if.pix_x   = x_q;
  assign fetch_if.pix_y   = y_q;

endmodule

// File: doc/ntsc_line_sequencer.md
Name: ntsc_line_sequencer

Overview:
- Sequences the NTSC composite line and frame timing around the colour decoder datapath at 50 MHz.
- Each line steps through sync, breezeway, colour burst, back porch, active video and front porch.
- Drives the 6-bit NES colour code into the colour decoder and a level-select to the DAC output mux.
- Fetches pixels from the frame buffer over a request/valid handshake.

Parameters:
- LINE_CLKS, 3175, clocks per line (63.5 us)
- HSYNC_CLKS, 235, sync tip width (4.7 us)
- BREEZE_CLKS, 30, breezeway width
- BURST_CLKS, 125, colour burst width (about 9 subcarrier cycles)
- BPORCH_CLKS, 80, back porch width
- FPORCH_CLKS, 75, front porch width
- PIX_CLKS, 10, clocks per pixel
- H_PIXELS, 256, visible pixels per line
- V_LINES, 262, lines per frame
- V_FIRST, 22, first visible line
- V_PIXELS, 240, visible lines
- BURST_COLOUR, 6'h08, code driven during burst
- BORDER_COLOUR, 6'h0F, code outside the pixel window and on underrun

Ports:
- clk, input, 1, 50 MHz clock
- reset, input, 1, asynchronous, active-high
- colour_num, output, 6, code to colour decoder
- video_sel, output, 2, 0 = sync, 1 = blank, 2 = burst, 3 = active
- pix_req, output, 1, pixel fetch request
- pix_x, output, 8, requested pixel column
- pix_y, output, 8, requested pixel row
- pix_valid, input, 1, fetch data valid
- pix_colour, input, 6, fetched colour code
- line_start, output, 1, one-cycle pulse at h_cnt = 0
- frame_start, output, 1, one-cycle pulse at h_cnt = 0, v_cnt = 0
- underrun, output, 1, sticky flag; cleared only by reset

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: all counters 0; state SYNC; colour_num = BORDER_COLOUR; video_sel = 0; pix_req, line_start, frame_start and underrun all 0.
- h_cnt counts 0..LINE_CLKS-1, then wraps to 0.
- v_cnt increments on the h_cnt wrap and wraps at V_LINES-1 to 0.
- State is decoded from h_cnt boundaries: SYNC [0, 235), BREEZE [235, 265), BURST [265, 390), BPORCH [390, 470), ACTIVE [470, 3100), FPORCH [3100, 3175).
- video_sel mapping per state: SYNC = 0; BREEZE, BPORCH and FPORCH = 1; BURST = 2 with colour_num = BURST_COLOUR; ACTIVE = 3.
- Pixel window: starts at ACTIVE start + 35 and lasts H_PIXELS*PIX_CLKS = 2560 clocks.
  - Applies only on lines with V_FIRST ≤ v_cnt < V_FIRST+V_PIXELS.
  - Outside the window while in ACTIVE: colour_num = BORDER_COLOUR.
- Fetch handshake:
  - pix_req pulses high for one cycle exactly PIX_CLKS clocks before pixel n is displayed.
  - pix_x = n and pix_y = v_cnt − V_FIRST, both held until the next request.
  - pix_valid may arrive in any cycle up to and including the display cycle.
  - The value is latched and displayed for PIX_CLKS clocks starting at the pixel boundary.
  - If pix_valid has not arrived by the display cycle: show BORDER_COLOUR for that pixel and set underrun.
  - A late pix_valid for a pixel already shown is discarded.
  - pix_valid outside a pending request is ignored.
- Output registering: colour_num and video_sel are registered with one clock latency from the h_cnt decode. Pulse positions above are referenced to the registered outputs.
- Vertical sync lines (v_cnt 3..5, macro off): video_sel = 0 for h_cnt < LINE_CLKS − HSYNC_CLKS, and 1 for the rest of the line.
  - No burst and no pixel requests on lines 0..8.
- Reset asserted mid-line: outputs return to reset values immediately. After release, counting restarts at h_cnt = 0, v_cnt = 0 and a frame_start pulse follows.

Optional Feature:
- VSYNC_SERRATION_EN defined:
  - Lines 0..2 and 6..8 are equalizing lines: sync low for 115 clocks at h_cnt 0 and again at 1587.
  - Lines 3..5 are serrated: sync low except 235-clock high gaps ending at h_cnt 1587 and at 3175.
- Undefined: plain broad-pulse vertical sync as described in Behaviour.

Decomposition:
- Package ntsc_timing_pkg:
  - state enum: SYNC, BREEZE, BURST, BPORCH, ACTIVE, FPORCH
  - video_sel encodings
  - derived boundary constants
- Sub-module ntsc_hv_counter: h_cnt/v_cnt counters with wrap and the line_start/frame_start pulses.

Test Plan:
- Release reset, run 2 lines → line_start period 3175 clocks; video_sel sequence 0(235), 1(30), 2(125), 1(80), 3(2630), 1(75).
- Frame run → frame_start every 262*3175 = 831850 clocks; lines 3..5 show video_sel = 0 for 2940 clocks and never 2.
- Line 22, zero-latency responder returning pix_colour = pix_x[5:0] → colour_num ramps 0..63 repeating across 2560 clocks, 10 clocks per value; 256 pix_req pulses; underrun stays 0.
- Responder withholds pix_valid for pixel 17 on line 40 → that pixel shows 6'h0F, underrun = 1 and stays set; neighbouring pixels are correct.
- Line 10 (outside window) → ACTIVE shows BORDER_COLOUR throughout; no pix_req.
- Assert reset at h_cnt = 1000 of line 50 → video_sel = 0 and colour_num = 6'h0F immediately; after release, frame_start occurs one clock after the first edge.
